csa_result_checker: RTL
=======================

# csa_result_checker

Synthesizable response checker for the carry-select adder family (`CSA_<N>`). It sits on the adder's output side, opposite the stimulus generator. Each accepted vector has its operands and the DUT's `{cout, sum}` captured, compared against a golden `a + b + cin`, and counted. At the end of a programmed run it reports pass/fail, the error count and the first failing vector, so adder regressions are self-checking on silicon or in simulation.

## Interface
- `WIDTH`, 2, operand/sum width; matches the adder under check.
- `CNT_W`, 16, width of the vector and error counters.
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `num_vectors`  in  CNT_W  vectors in the run; sampled with `start`.
- `in_valid`  in  1  the `a`/`b`/`cin`/`sum`/`cout` inputs hold one vector this cycle.
- `a`, `b`  in  WIDTH  operands applied to the DUT.
- `cin`  in  1  carry-in applied to the DUT.
- `sum`  in  WIDTH  DUT sum.
- `cout`  in  1  DUT carry-out.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`; 1 iff `err_count == 0`.
- `err_count`  out  CNT_W  mismatches in the current/last run; saturating.
- `vec_count`  out  CNT_W  vectors accepted in the current/last run.
- `fail_idx`  out  CNT_W  `vec_count` value at the first mismatch.
- `fail_vec`  out  2*WIDTH+1  `{a, b, cin}` of the first mismatch.
- `fail_got`, `fail_exp`  out  WIDTH+1  DUT `{cout,sum}` and golden value at the first mismatch.
- `cov_full`  out  1  every `{a,b,cin}` combination seen this run (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start=1`: clear every counter and capture register, latch `num_vectors` as the target. Go to RUN, or to DONE if the target is 0.
  - RUN, `in_valid=1`: accept the vector. Compute `exp = a + b + cin` at width WIDTH+1 with zero extension. If `{cout,sum} != exp`, increment `err_count`, saturating at all-ones. If this is the first error, load `fail_idx = vec_count` (the pre-increment value), `fail_vec`, `fail_got` and `fail_exp`. Increment `vec_count`. If the new `vec_count` equals the target, go to DONE.
  - RUN: `start` is ignored. `in_valid=0` holds all state.
  - DONE: results are held. `in_valid` is ignored. `start=1` behaves as in IDLE (clear, relatch, go to RUN or DONE).
- Reset values: state IDLE; `busy`, `done`, `pass`, `cov_full` 0; all counters and capture registers 0.
- Reset asserted mid-run aborts the run and returns the block to reset values. No partial results are retained.
- `pass` is driven 0 outside DONE.
- `vec_count` wraps only if the target is all-ones and more vectors are supplied. This cannot happen, because the run ends at the target.
- The golden arithmetic is a single adder. No carry-select structure is replicated in the checker.

## Timing
- Compare latency is 1 cycle. `err_count`, `vec_count` and the capture registers reflect a vector on the edge that accepts it.
- `done` rises on the same edge that accepts the final vector. It is observable the following cycle.
- With `num_vectors=0`, `done=1` and `pass=1` one cycle after `start`.
- `start` and `in_valid` asserted together in IDLE or DONE: `start` wins and that vector is not counted.
- The checker accepts back-to-back vectors every cycle. There is no backpressure.

## Configuration
- `CSA_CHK_COVERAGE_EN` defined:
  - A 2^(2*WIDTH+1)-bit bitmap indexed by `{a,b,cin}` is set on each accepted vector and cleared on `start` and `reset`.
  - `cov_full` is registered, asserts the cycle after the last bit is set, and holds until clear.
- Not defined: no bitmap is built and `cov_full` is tied to 0.

## Test plan
- Correct DUT model, WIDTH=2, `num_vectors=32`, all 32 `{a,b,cin}` combinations: `done`, `pass=1`, `err_count=0`, `vec_count=32`, and `cov_full=1` when `CSA_CHK_COVERAGE_EN` is defined.
- Faulty vector: a=3, b=2, cin=1 with `{cout,sum}=3'b101` as the 5th vector (index 4) of 8: `pass=0`, `err_count=1`, `fail_idx=4`, `fail_vec=5'b11101`, `fail_got=3'b101`, `fail_exp=3'b110`.
- Every vector wrong, CNT_W=2, `num_vectors=3`: `err_count=3` with no wrap, and the capture registers hold the first vector.
- `num_vectors=0`: `done=1` and `pass=1` one cycle after `start`, `vec_count=0`.
- `reset` pulsed after 5 of 10 vectors: all outputs at reset values. A fresh `start` with 10 correct vectors gives `pass=1`.
- `start` and `in_valid` high together in DONE: counters cleared and that vector not counted. `in_valid` gaps mid-run do not advance `vec_count`.

Source files
------------

// File: rtl/csa_result_checker.sv
// Response checker for the CSA_<N> adder family: compares {cout,sum} against a golden a+b+cin,
// counts vectors/errors and captures the first failure. Optional coverage bitmap: CSA_CHK_COVERAGE_EN.
module csa_result_checker #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   num_vectors_i,
    input  logic               in_valid_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               cin_i,
    input  logic [WIDTH-1:0]   sum_i,
    input  logic               cout_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [CNT_W-1:0]   err_count_o,
    output logic [CNT_W-1:0]   vec_count_o,
    output logic [CNT_W-1:0]   fail_idx_o,
    output logic [2*WIDTH:0]   fail_vec_o,
    output logic [WIDTH:0]     fail_got_o,
    output logic [WIDTH:0]     fail_exp_o,
    output logic               cov_full_o
);

    localparam int unsigned VecW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic               busy_q, done_q, pass_q;
    logic [CNT_W-1:0]   target_q, err_q, vec_q, fidx_q;
    logic [VecW-1:0]    fvec_q;
    logic [WIDTH:0]     fgot_q, fexp_q;

    logic [WIDTH:0]     exp_sum, got_sum;
    logic               mismatch;
    logic [VecW-1:0]    vec_idx;
    logic [CNT_W-1:0]   vec_inc;
    logic               start_ok, accept;

    // Single golden adder; the carry-select structure is deliberately not replicated.
    assign exp_sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    assign got_sum  = {cout_i, sum_i};
    assign mismatch = (got_sum != exp_sum);
    assign vec_idx  = {a_i, b_i, cin_i};
    assign vec_inc  = vec_q + CNT_W'(1);
    assign start_ok = start_i && (state_q != StRun);
    assign accept   = in_valid_i && (state_q == StRun);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            target_q <= '0;
            err_q    <= '0;
            vec_q    <= '0;
            fidx_q   <= '0;
            fvec_q   <= '0;
            fgot_q   <= '0;
            fexp_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        target_q <= num_vectors_i;
                        err_q    <= '0;
                        vec_q    <= '0;
                        fidx_q   <= '0;
                        fvec_q   <= '0;
                        fgot_q   <= '0;
                        fexp_q   <= '0;
                        if (num_vectors_i == '0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (in_valid_i) begin
                        if (mismatch) begin
                            if (err_q != '1) err_q <= err_q + CNT_W'(1);
                            // err_q never returns to zero, so zero marks the first failure
                            if (err_q == '0) begin
                                fidx_q <= vec_q;
                                fvec_q <= vec_idx;
                                fgot_q <= got_sum;
                                fexp_q <= exp_sum;
                            end
                        end
                        vec_q <= vec_inc;
                        if (vec_inc == target_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == '0) && !mismatch;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CSA_CHK_COVERAGE_EN
    logic [2**VecW-1:0] cov_q;
    logic               cov_full_q;

    always_ff @(posedge clock_i) begin
        if (reset_i || start_ok) begin
            cov_q      <= '0;
            cov_full_q <= 1'b0;
        end else begin
            if (accept) cov_q[vec_idx] <= 1'b1;
            cov_full_q <= &cov_q;
        end
    end

    assign cov_full_o = cov_full_q;
`else
    assign cov_full_o = 1'b0;
`endif

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign vec_count_o = vec_q;
    assign fail_idx_o  = fidx_q;
    assign fail_vec_o  = fvec_q;
    assign fail_got_o  = fgot_q;
    assign fail_exp_o  = fexp_q;

endmodule
